ulpb_ctrl_gen2: RTL and testbench

- Parametrised second-generation bus controller for the ULPB ring.
- Detects a start condition on DIN and generates the bus clock CLK_OUT.
- Forwards DIN to DOUT during the data phase, tracks the message marker and the ACK sequence, and detects out-of-phase glitches.
- Terminates every transaction with a self-checked reset sequence. Adds configurable reset/ACK patterns, a reset-phase clock divider, a bit-count watchdog, an abort request and status outputs.

---
 rtl/ulpb_ctrl_gen2_if.sv | 21 ++
 rtl/ulpb_ctrl_gen2.sv | 235 +++++++++++++++++++++++
 tb/tb_ulpb_ctrl_gen2.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ulpb_ctrl_gen2_if.sv
// Bus-side signal bundle of the ULPB gen2 ring controller.
// master is the controller end, slave is the ring/upstream end.
interface ulpb_ctrl_gen2_if;
    logic       DIN;
    logic       ABORT;
    logic       DOUT;
    logic       CLK_OUT;
    logic       BUSY;
    logic       RST_DONE;
    logic [1:0] ERR_CODE;
    logic [4:0] STATE;

    modport master (
        input  DIN, ABORT,
        output DOUT, CLK_OUT, BUSY, RST_DONE, ERR_CODE, STATE
    );
    modport slave (
        output DIN, ABORT,
        input  DOUT, CLK_OUT, BUSY, RST_DONE, ERR_CODE, STATE
    );
endinterface

// File: rtl/ulpb_ctrl_gen2.sv
// ULPB ring controller: start detection, bus clock generation, data pass-through with
// marker/ACK tracking, and a self-checked reset sequence closing every transaction.
module ulpb_ctrl_gen2 #(
    parameter int unsigned          START_CYCLES = 12,
    parameter int unsigned          CLK_DIV      = 2,
    parameter int unsigned          RST_LEN      = 3,
    parameter logic [RST_LEN-1:0]   RST_PATTERN  = 3'b010,
    parameter int unsigned          ACK_LEN      = 4,
    parameter logic [ACK_LEN-1:0]   ACK_PATTERN  = 4'b1010,
    parameter logic [1:0]           MES_SEQ      = 2'b10,
    parameter int unsigned          MAX_BITS     = 0
) (
    input logic              CLK,
    input logic              RESET,
    ulpb_ctrl_gen2_if.master bus
);
    localparam int unsigned StW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int unsigned DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RW  = $clog2(RST_LEN + 1);
    localparam int unsigned SW  = $clog2(ACK_LEN + 1);

    localparam logic [StW-1:0] StartLoad = StW'(START_CYCLES - 1);
    localparam logic [DW-1:0]  DivLast   = DW'(CLK_DIV - 1);
    localparam logic [RW-1:0]  RidxLast  = RW'(RST_LEN - 1);
    localparam logic [SW-1:0]  SeqLast   = SW'(ACK_LEN);
    localparam logic [15:0]    MaxBits   = 16'(MAX_BITS);

    typedef enum logic [4:0] {
        StIdle, StWaitStart, StEnClkNeg, StArbPos, StArbNeg, StDrvPos, StDrvNeg, StLatPos,
        StLatNeg, StRdNeg, StRdPos, StRlNeg, StRlPos, StRelDNeg, StRelDPos, StRelLNeg,
        StRelLPos, StBackNeg, StBackPos
    } state_e;

    state_e           state_q, state_d;
    logic [StW-1:0]   start_cnt_q, start_cnt_d;
    logic [DW-1:0]    div_q, div_d;
    logic [RW-1:0]    ridx_q, ridx_d;
    logic [SW-1:0]    seq_q, seq_d;
    logic [15:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic             parity_q, parity_d, last_q, last_d, din_q, bad_q, bad_d;
    logic             hold_q, hold_d, ctrl_dout_q, ctrl_dout_d, clk_out_q, clk_out_d;
    logic             rst_done_q, rst_done_d;
    logic [1:0]       err_q, err_d;

    logic             enter_rst, first, last, mism, bad_now, in_div;
    logic [1:0]       err_new;
    logic [ACK_LEN-1:0] ack_tmp;
    logic [RST_LEN-1:0] rst_tmp;

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        div_d       = div_q;
        ridx_d      = ridx_q;
        seq_d       = seq_q;
        bit_cnt_d   = bit_cnt_q;
        retry_d     = retry_q;
        parity_d    = parity_q;
        last_d      = last_q;
        bad_d       = bad_q;
        hold_d      = hold_q;
        ctrl_dout_d = ctrl_dout_q;
        err_d       = err_q;
        rst_done_d  = 1'b0;
        enter_rst   = 1'b0;
        err_new     = 2'd0;
        first       = (div_q == '0);
        last        = (div_q == DivLast);
        mism        = (bus.DIN != ctrl_dout_q);
        bad_now     = ((state_q == StRdNeg) ? 1'b0 : bad_q) | (first & mism);
        ack_tmp     = ACK_PATTERN << (seq_q - 1'b1);
        rst_tmp     = RST_PATTERN << (ridx_q + 1'b1);
        in_div      = state_q inside {StRdNeg, StRdPos, StRlNeg, StRlPos, StRelDNeg, StRelDPos,
                                      StRelLNeg, StRelLPos, StBackNeg, StBackPos};
        if (in_div) begin
            div_d = last ? '0 : div_q + 1'b1;
            if (first && state_q inside {StRdNeg, StRdPos, StRlNeg, StRlPos}) bad_d = bad_now;
        end

        case (state_q)
            StIdle: begin
                start_cnt_d = StartLoad;
                seq_d       = '0;
                bit_cnt_d   = '0;
                retry_d     = '0;
                parity_d    = 1'b0;
                if (!bus.DIN) state_d = StWaitStart;
            end
            StWaitStart: begin
                if (start_cnt_q == '0) state_d = StEnClkNeg;
                else                   start_cnt_d = start_cnt_q - 1'b1;
            end
            StEnClkNeg: state_d = StArbPos;
            StArbPos:   state_d = StArbNeg;
            StArbNeg: begin
                state_d = StDrvPos;
                hold_d  = 1'b0;
            end
            StDrvPos:   state_d = StDrvNeg;
            StDrvNeg: begin
                // History is {DIN seen in DRV_POS, DIN now}; any change is a glitch.
                state_d = StLatPos;
                if (din_q != bus.DIN) begin
                    enter_rst = 1'b1;
                    err_new   = 2'd1;
                end else if (bus.ABORT) begin
                    enter_rst = 1'b1;
                    err_new   = 2'd3;
                end
            end
            StLatPos:   state_d = StLatNeg;
            StLatNeg: begin
                state_d   = StDrvPos;
                bit_cnt_d = (bit_cnt_q == 16'hFFFF) ? bit_cnt_q : bit_cnt_q + 16'd1;
                parity_d  = ~parity_q;
                last_d    = bus.DIN;
                if (bus.ABORT || (MAX_BITS != 0 && bit_cnt_d == MaxBits)) begin
                    enter_rst = 1'b1;
                    err_new   = 2'd3;
                end else if (seq_q == '0) begin
                    if (parity_q && (last_q != bus.DIN)) begin
                        if ({last_q, bus.DIN} == MES_SEQ) begin
                            seq_d = SW'(1);
                        end else begin
                            enter_rst = 1'b1;
                            err_new   = 2'd2;
                        end
                    end
                end else if (bus.DIN != ack_tmp[ACK_LEN-1]) begin
                    enter_rst = 1'b1;
                    err_new   = 2'd2;
                end else if (seq_q == SeqLast) begin
                    enter_rst = 1'b1;
                    err_new   = 2'd0;
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end
            StRdNeg:   if (last) state_d = StRdPos;
            StRdPos:   if (last) state_d = StRlNeg;
            StRlNeg:   if (last) state_d = StRlPos;
            StRlPos: begin
                if (last) begin
                    state_d = StRdNeg;
                    if (!bad_now && ridx_q == RidxLast) begin
                        ctrl_dout_d = 1'b1;
                        state_d     = StRelDNeg;
                    end else if (!bad_now) begin
                        ridx_d      = ridx_q + 1'b1;
                        ctrl_dout_d = rst_tmp[RST_LEN-1];
                    end else begin
                        ridx_d      = '0;
                        ctrl_dout_d = RST_PATTERN[RST_LEN-1];
                        retry_d     = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                    end
                end
            end
            StRelDNeg: if (last) state_d = StRelDPos;
            StRelDPos: if (last) state_d = StRelLNeg;
            StRelLNeg: if (last) state_d = StRelLPos;
            StRelLPos: if (last) state_d = StBackNeg;
            StBackNeg: if (last) state_d = StBackPos;
            StBackPos: begin
                if (last) begin
                    state_d    = StIdle;
                    rst_done_d = 1'b1;
                end
            end
            default:   state_d = StIdle;
        endcase

        if (enter_rst) begin
            state_d     = StRdNeg;
            hold_d      = 1'b1;
            ctrl_dout_d = RST_PATTERN[RST_LEN-1];
            ridx_d      = '0;
            div_d       = '0;
            err_d       = err_new;
        end

        // CLK_OUT is a registered function of the state being entered.
        clk_out_d = 1'b1;
        case (state_d)
            StEnClkNeg, StArbNeg, StDrvNeg, StLatNeg, StRdNeg, StRlNeg, StRelDNeg, StRelLNeg,
            StBackNeg: clk_out_d = 1'b0;
            default:   clk_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            start_cnt_q <= '0;
            div_q       <= '0;
            ridx_q      <= '0;
            seq_q       <= '0;
            bit_cnt_q   <= '0;
            retry_q     <= '0;
            parity_q    <= 1'b0;
            last_q      <= 1'b0;
            din_q       <= 1'b0;
            bad_q       <= 1'b0;
            hold_q      <= 1'b1;
            ctrl_dout_q <= 1'b1;
            clk_out_q   <= 1'b1;
            rst_done_q  <= 1'b0;
            err_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            div_q       <= div_d;
            ridx_q      <= ridx_d;
            seq_q       <= seq_d;
            bit_cnt_q   <= bit_cnt_d;
            retry_q     <= retry_d;
            parity_q    <= parity_d;
            last_q      <= last_d;
            din_q       <= bus.DIN;
            bad_q       <= bad_d;
            hold_q      <= hold_d;
            ctrl_dout_q <= ctrl_dout_d;
            clk_out_q   <= clk_out_d;
            rst_done_q  <= rst_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.DOUT     = hold_q ? ctrl_dout_q : bus.DIN;
    assign bus.CLK_OUT  = clk_out_q;
    assign bus.BUSY     = (state_q != StIdle);
    assign bus.RST_DONE = rst_done_q;
    assign bus.ERR_CODE = err_q;
    assign bus.STATE    = state_q;
endmodule

// File: tb/tb_ulpb_ctrl_gen2.sv
// Directed bench for ulpb_ctrl_gen2: a default instance and a MAX_BITS=8 / CLK_DIV=1 instance
// share the clock and reset; sel routes the driven DIN/ABORT to one of them.
module tb_ulpb_ctrl_gen2;
    logic CLK, RESET, sel, din, abort;
    int   checks, failures;

    ulpb_ctrl_gen2_if bus0 ();
    ulpb_ctrl_gen2_if bus1 ();

    assign bus0.DIN   = sel ? 1'b1 : din;
    assign bus0.ABORT = sel ? 1'b0 : abort;
    assign bus1.DIN   = sel ? din : 1'b1;
    assign bus1.ABORT = sel ? abort : 1'b0;

    ulpb_ctrl_gen2 dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0));
    ulpb_ctrl_gen2 #(.MAX_BITS(8), .CLK_DIV(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From IDLE: start condition, 12 start cycles, 3 arbitration half-periods -> DRV_POS.
    task automatic start_tx();
        din = 1'b0;
        tick(16);
    endtask

    task automatic send_bit(input logic b);
        din = b;
        tick(4);
    endtask

    task automatic rst_bit(input logic b, input int div);
        din = b;
        tick(4 * div);
    endtask

    initial begin
        logic [9:0] msg;
        logic [6:0] eq_bits;
        checks   = 0;
        failures = 0;
        RESET    = 1'b0;
        sel      = 1'b0;
        din      = 1'b1;
        abort    = 1'b0;
        tick(2);
        chk("rst_dout", 8'(bus0.DOUT), 8'd1);
        chk("rst_clk_out", 8'(bus0.CLK_OUT), 8'd1);
        chk("rst_busy", 8'(bus0.BUSY), 8'd0);
        chk("rst_done", 8'(bus0.RST_DONE), 8'd0);
        chk("rst_err", 8'(bus0.ERR_CODE), 8'd0);
        chk("rst_state", 8'(bus0.STATE), 8'd0);
        RESET = 1'b1;
        tick(1);
        chk("idle_hold", 8'(bus0.STATE), 8'd0);

        // Start detection and clock generation timing
        din = 1'b0;
        tick(1);
        chk("wait_state", 8'(bus0.STATE), 8'd1);
        chk("wait_busy", 8'(bus0.BUSY), 8'd1);
        tick(11);
        chk("wait_12_state", 8'(bus0.STATE), 8'd1);
        chk("wait_12_clk", 8'(bus0.CLK_OUT), 8'd1);
        tick(1);
        chk("en_clk_state", 8'(bus0.STATE), 8'd2);
        chk("en_clk_fall", 8'(bus0.CLK_OUT), 8'd0);
        tick(3);
        chk("drv_pos_state", 8'(bus0.STATE), 8'd5);
        chk("drv_pos_clk", 8'(bus0.CLK_OUT), 8'd1);
        din = 1'b1;
        #1;
        chk("pass_dout_1", 8'(bus0.DOUT), 8'd1);
        din = 1'b0;
        #1;
        chk("pass_dout_0", 8'(bus0.DOUT), 8'd0);

        // Data, marker {1,0}, ACK 1,0,1,0 -> normal end
        msg = 10'b1100101010;
        for (int i = 9; i >= 0; i--) send_bit(msg[i]);
        chk("ok_state", 8'(bus0.STATE), 8'd9);
        chk("ok_err", 8'(bus0.ERR_CODE), 8'd0);
        chk("ok_rst_dout", 8'(bus0.DOUT), 8'd0);
        chk("ok_rst_clk", 8'(bus0.CLK_OUT), 8'd0);
        chk("ok_rst_done_busy", 8'(bus0.RST_DONE), 8'd0);
        din = 1'b0;
        tick(2);
        chk("rd_pos_state", 8'(bus0.STATE), 8'd10);
        chk("rd_pos_clk", 8'(bus0.CLK_OUT), 8'd1);
        tick(6);
        chk("rbit1_dout", 8'(bus0.DOUT), 8'd1);
        rst_bit(1'b1, 2);
        chk("rbit2_dout", 8'(bus0.DOUT), 8'd0);
        rst_bit(1'b0, 2);
        chk("rel_state", 8'(bus0.STATE), 8'd13);
        chk("rel_dout", 8'(bus0.DOUT), 8'd1);
        din = 1'b1;
        tick(11);
        chk("back_pos_state", 8'(bus0.STATE), 8'd18);
        chk("back_pos_done", 8'(bus0.RST_DONE), 8'd0);
        tick(1);
        chk("done_state", 8'(bus0.STATE), 8'd0);
        chk("done_pulse", 8'(bus0.RST_DONE), 8'd1);
        chk("done_busy", 8'(bus0.BUSY), 8'd0);
        tick(1);
        chk("done_pulse_end", 8'(bus0.RST_DONE), 8'd0);

        // Glitch between DRV_POS and DRV_NEG
        start_tx();
        din = 1'b1;
        tick(1);
        chk("glitch_drv_neg", 8'(bus0.STATE), 8'd6);
        din = 1'b0;
        tick(1);
        chk("glitch_state", 8'(bus0.STATE), 8'd9);
        chk("glitch_err", 8'(bus0.ERR_CODE), 8'd1);
        chk("glitch_dout", 8'(bus0.DOUT), 8'd0);
        rst_bit(1'b0, 2);
        rst_bit(1'b1, 2);
        rst_bit(1'b0, 2);
        din = 1'b1;
        tick(12);
        chk("glitch_done", 8'(bus0.RST_DONE), 8'd1);

        // Third ACK bit wrong, then a corrupted second reset bit
        start_tx();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("ack_ok_so_far", 8'(bus0.STATE), 8'd5);
        send_bit(1'b0);
        chk("ack_bad_state", 8'(bus0.STATE), 8'd9);
        chk("ack_bad_err", 8'(bus0.ERR_CODE), 8'd2);
        rst_bit(1'b0, 2);
        chk("retry_bit1", 8'(bus0.DOUT), 8'd1);
        rst_bit(1'b0, 2);
        chk("retry_restart_dout", 8'(bus0.DOUT), 8'd0);
        chk("retry_restart_state", 8'(bus0.STATE), 8'd9);
        rst_bit(1'b0, 2);
        rst_bit(1'b1, 2);
        rst_bit(1'b0, 2);
        chk("retry_rel", 8'(bus0.STATE), 8'd13);
        din = 1'b1;
        tick(12);
        chk("retry_done", 8'(bus0.RST_DONE), 8'd1);
        chk("retry_err_kept", 8'(bus0.ERR_CODE), 8'd2);

        // ABORT sampled in DRV_NEG
        start_tx();
        send_bit(1'b1);
        send_bit(1'b1);
        abort = 1'b1;
        tick(1);
        chk("abort_drv_neg", 8'(bus0.STATE), 8'd6);
        tick(1);
        abort = 1'b0;
        chk("abort_state", 8'(bus0.STATE), 8'd9);
        chk("abort_err", 8'(bus0.ERR_CODE), 8'd3);

        // Asynchronous reset mid reset-sequence
        din = 1'b0;
        tick(3);
        chk("mid_rst_busy", 8'(bus0.STATE), 8'd10);
        RESET = 1'b0;
        #1;
        chk("async_state", 8'(bus0.STATE), 8'd0);
        chk("async_dout", 8'(bus0.DOUT), 8'd1);
        chk("async_clk", 8'(bus0.CLK_OUT), 8'd1);
        chk("async_busy", 8'(bus0.BUSY), 8'd0);
        chk("async_err", 8'(bus0.ERR_CODE), 8'd0);
        din = 1'b1;
        tick(1);
        RESET = 1'b1;
        tick(1);

        // Watchdog at 8 bits with CLK_DIV=1
        sel = 1'b1;
        start_tx();
        eq_bits = 7'b1100110;
        for (int i = 6; i >= 0; i--) send_bit(eq_bits[i]);
        chk("wd_before", 8'(bus1.STATE), 8'd5);
        send_bit(1'b0);
        chk("wd_state", 8'(bus1.STATE), 8'd9);
        chk("wd_err", 8'(bus1.ERR_CODE), 8'd3);
        chk("wd_dout", 8'(bus1.DOUT), 8'd0);
        chk("wd_clk", 8'(bus1.CLK_OUT), 8'd0);
        din = 1'b0;
        tick(1);
        chk("div1_rd_pos", 8'(bus1.STATE), 8'd10);
        chk("div1_clk", 8'(bus1.CLK_OUT), 8'd1);
        tick(3);
        chk("div1_bit1_state", 8'(bus1.STATE), 8'd9);
        chk("div1_bit1_dout", 8'(bus1.DOUT), 8'd1);
        rst_bit(1'b1, 1);
        rst_bit(1'b0, 1);
        chk("div1_rel", 8'(bus1.STATE), 8'd13);
        din = 1'b1;
        tick(5);
        chk("div1_back_pos", 8'(bus1.STATE), 8'd18);
        tick(1);
        chk("div1_idle", 8'(bus1.STATE), 8'd0);
        chk("div1_done", 8'(bus1.RST_DONE), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
